// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared defaults and FSM state encoding for the serial FIR
//                tap scheduler and its multiply-accumulate unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

   // Default geometry: 4 taps, 8-bit samples and coefficients.
   // The accumulator has DW+CW+clog2(NTAPS) bits, so it cannot overflow.
   localparam int C_NTAPS = 4;
   localparam int C_DW    = 8;
   localparam int C_CW    = 8;
   localparam int C_OW    = 18;
   localparam int C_IW    = $clog2(C_NTAPS);

   // Scheduler FSM encoding
   localparam logic [1:0] C_ST_IDLE = 2'd0;
   localparam logic [1:0] C_ST_MAC  = 2'd1;
   localparam logic [1:0] C_ST_DONE = 2'd2;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_unit
//  Description : Single shared signed multiplier and accumulator. Each enabled
//                cycle adds a*b, sign-extended to OW bits, to the register.
//                The clear input has priority over the enable input.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_unit #(
   parameter int DW = 8,
   parameter int CW = 8,
   parameter int OW = 18
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [CW-1:0] b,
   output logic signed [OW-1:0] acc
);

   logic signed [DW+CW-1:0] prod;
   logic signed [OW-1:0]    prod_ext;
   logic signed [OW-1:0]    acc_q;

   // Full-precision product. The signed cast keeps the sign when widening.
   assign prod     = a * b;
   assign prod_ext = OW'(prod);

   // Accumulator register. Clear starts a new sample and en adds one tap.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= acc_q + prod_ext;
      end
   end

   assign acc = acc_q;

endmodule : fir_mac_unit
`default_nettype wire

// File: rtl/fir_tap_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_scheduler
//  Description : Serial FIR controller. Each accepted sample enters the delay
//                line and is swept through NTAPS taps, one tap per clock, on a
//                single shared MAC. The block emits one result pulse per sample.
//                Coefficients can be loaded at run time while the block is idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_scheduler
   import fir_pkg::*;
#(
   parameter int NTAPS = C_NTAPS,
   parameter int DW    = C_DW,
   parameter int CW    = C_CW,
   parameter int OW    = C_OW,
   localparam int IW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] Xin,
   input  logic                 coef_we,
   input  logic [IW-1:0]        coef_addr,
   input  logic signed [CW-1:0] coef_data,
   output logic                 out_valid,
   output logic signed [OW-1:0] Yout,
   output logic                 busy
);

   logic [1:0]           state_q;
   logic [1:0]           state_d;
   logic [IW-1:0]        k_q;
   logic [IW-1:0]        k_d;
   logic signed [DW-1:0] x_q [NTAPS];
   logic signed [CW-1:0] h_q [NTAPS];
   logic signed [OW-1:0] yout_q;
   logic signed [OW-1:0] acc;

   logic                 is_idle;
   logic                 is_mac;
   logic                 is_done;
   logic                 accept;
   logic                 last_tap;
   logic [31:0]          addr_ext;
   logic                 addr_ok;
   logic                 coef_commit;

   assign is_idle  = (state_q == C_ST_IDLE);
   assign is_mac   = (state_q == C_ST_MAC);
   assign is_done  = (state_q == C_ST_DONE);
   assign accept   = is_idle && in_valid;
   assign last_tap = (k_q == IW'(NTAPS - 1));

   // Coefficient writes land only while idle and only for existing taps.
   // The address is compared at 32 bits so the range check holds for any NTAPS.
   assign addr_ext    = 32'(coef_addr);
   assign addr_ok     = (addr_ext < 32'(NTAPS));
   assign coef_commit = coef_we && is_idle && addr_ok;

   assign in_ready  = is_idle;
   assign busy      = !is_idle;
   assign out_valid = is_done;

   // In DONE the accumulator already holds the final sum, so Yout shows it directly.
   // Afterwards the captured copy holds the result until the next pulse.
   assign Yout = is_done ? acc : yout_q;

   // Next-state and tap-index logic
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         C_ST_IDLE: begin
            if (accept) begin
               state_d = C_ST_MAC;
               k_d     = '0;
            end
         end
         C_ST_MAC: begin
            if (last_tap) begin
               state_d = C_ST_DONE;
               k_d     = '0;
            end else begin
               k_d     = k_q + IW'(1);
            end
         end
         C_ST_DONE: begin
            state_d = C_ST_IDLE;
         end
         default: begin
            state_d = C_ST_IDLE;
            k_d     = '0;
         end
      endcase
   end

   // State and tap-index registers
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= C_ST_IDLE;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Delay line: shift in the new sample when it is accepted.
   // Coefficient writes do not disturb this history.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= '0;
         end
      end else if (accept) begin
         for (int i = NTAPS - 1; i > 0; i--) begin
            x_q[i] <= x_q[i-1];
         end
         x_q[0] <= Xin;
      end
   end

   // Coefficient file. A write and a sample accepted in the same cycle both
   // commit on that edge, so the following MAC sweep already uses the new value.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < NTAPS; i++) begin
            h_q[i] <= '0;
         end
      end else if (coef_commit) begin
         h_q[coef_addr] <= coef_data;
      end
   end

   // Capture the finished result so Yout holds it between pulses.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         yout_q <= '0;
      end else if (is_done) begin
         yout_q <= acc;
      end
   end

   fir_mac_unit #(
      .DW (DW),
      .CW (CW),
      .OW (OW)
   ) u_mac (
      .Clk (Clk),
      .Rst (Rst),
      .clr (accept),
      .en  (is_mac),
      .a   (x_q[k_q]),
      .b   (h_q[k_q]),
      .acc (acc)
   );

endmodule : fir_tap_scheduler
`default_nettype wire

// File: tb/tb_fir_tap_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tap_scheduler
//  Description : Self-checking bench for fir_tap_scheduler. A reference model
//                queues the expected result for each accepted sample. The
//                monitor pops one entry on every out_valid pulse and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tap_scheduler;

   localparam int NTAPS = 4;
   localparam int DW    = 8;
   localparam int CW    = 8;
   localparam int OW    = 18;
   localparam int IW    = 2;

   logic                 Clk = 1'b0;
   logic                 Rst;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] Xin;
   logic                 coef_we;
   logic [IW-1:0]        coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 out_valid;
   logic signed [OW-1:0] Yout;
   logic                 busy;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_q[$];
   int mx[NTAPS];
   int mh[NTAPS];

   fir_tap_scheduler #(
      .NTAPS (NTAPS),
      .DW    (DW),
      .CW    (CW),
      .OW    (OW)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Xin       (Xin),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .Yout      (Yout),
      .busy      (busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int wrap_ow(input int v);
      return (v <<< (32 - OW)) >>> (32 - OW);
   endfunction

   task automatic model_accept(input int x);
      int acc;
      for (int i = NTAPS - 1; i > 0; i--) mx[i] = mx[i-1];
      mx[0] = x;
      acc = 0;
      for (int k = 0; k < NTAPS; k++) acc += mh[k] * mx[k];
      exp_q.push_back(wrap_ow(acc));
   endtask

   task automatic model_wr(input int a, input int d);
      if (a < NTAPS) mh[a] = d;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NTAPS; i++) begin
         mx[i] = 0;
         mh[i] = 0;
      end
      exp_q.delete();
   endtask

   // Every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) check("unexpected_out_valid", 1, 0);
         else check("yout", int'(Yout), exp_q.pop_front());
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr_coef(input int a, input int d);
      coef_we   = 1'b1;
      coef_addr = a[IW-1:0];
      coef_data = d[CW-1:0];
      cyc();
      coef_we   = 1'b0;
      model_wr(a, d);
   endtask

   task automatic send(input int x);
      bit got = 1'b0;
      in_valid = 1'b1;
      Xin      = x[DW-1:0];
      for (int t = 0; t <= 30; t++) begin
         @(negedge Clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("send_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         @(posedge Clk);
         model_accept(x);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 40; t++) begin
         if (exp_q.size() == 0) break;
         @(posedge Clk);
      end
      #1;
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int imp_x[5];
      int imp_y[5];
      int stp_y[4];

      imp_x = '{1, 0, 0, 0, 0};
      imp_y = '{-2, -1, 3, 4, 0};
      stp_y = '{-20, -30, 0, 40};

      model_reset();
      Rst = 1'b1; in_valid = 1'b0; Xin = '0;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b0;

      // Reset state
      @(negedge Clk);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_yout", int'(Yout), 0);
      cyc();

      // Impulse response with h = {-2,-1,3,4}
      wr_coef(0, -2); wr_coef(1, -1); wr_coef(2, 3); wr_coef(3, 4);
      for (int i = 0; i < 5; i++) begin
         send(imp_x[i]);
         wait_drain();
         check("impulse_hold", int'(Yout), imp_y[i]);
      end

      // Step response
      for (int i = 0; i < 4; i++) begin
         send(10);
         wait_drain();
         check("step_hold", int'(Yout), stp_y[i]);
      end

      // Handshake timing: sample 5 at cycle 0. Sample 7 is offered from cycle 2
      // and must not be taken before cycle 6.
      in_valid = 1'b1;
      Xin      = 8'sd5;
      @(negedge Clk);
      check("tim_ready_c0", int'(in_ready), 1);
      @(posedge Clk);
      model_accept(5);
      #1;
      for (int c = 1; c <= 6; c++) begin
         if (c == 2) Xin = 8'sd7;
         @(negedge Clk);
         check($sformatf("tim_ready_c%0d", c), int'(in_ready), (c == 6) ? 1 : 0);
         check($sformatf("tim_busy_c%0d", c), int'(busy), (c == 6) ? 0 : 1);
         check($sformatf("tim_oval_c%0d", c), int'(out_valid), (c == 5) ? 1 : 0);
         if (c < 6) cyc();
      end
      @(posedge Clk);
      model_accept(7);
      #1 in_valid = 1'b0;
      wait_drain();

      // Extreme operands, no wrap
      for (int i = 0; i < NTAPS; i++) wr_coef(i, -128);
      for (int i = 0; i < NTAPS; i++) begin
         send(-128);
         wait_drain();
      end
      check("max_no_wrap", int'(Yout), 65536);

      // A coefficient write during MAC must be dropped
      in_valid = 1'b1;
      Xin      = 8'sd1;
      @(negedge Clk);
      @(posedge Clk);
      model_accept(1);
      #1 in_valid = 1'b0;
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd7;
      cyc();
      coef_we = 1'b0;
      wait_drain();
      check("mac_write_ignored", int'(Yout), 49024);

      // A write in the same cycle as an accepted sample takes effect at once
      in_valid = 1'b1; Xin = 8'sd2;
      coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd7;
      @(negedge Clk);
      check("same_cycle_ready", int'(in_ready), 1);
      @(posedge Clk);
      model_wr(0, 7);
      model_accept(2);
      #1 in_valid = 1'b0; coef_we = 1'b0;
      wait_drain();
      check("same_cycle_write", int'(Yout), 32654);

      // Reset in the middle of MAC aborts the sample
      in_valid = 1'b1; Xin = 8'sd3;
      @(negedge Clk);
      @(posedge Clk);
      model_accept(3);
      #1 in_valid = 1'b0;
      cyc();
      Rst = 1'b1;
      model_reset();
      cyc();
      Rst = 1'b0;
      @(negedge Clk);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_yout", int'(Yout), 0);
      check("abort_ready", int'(in_ready), 1);
      check("abort_busy", int'(busy), 0);
      repeat (8) cyc();

      // Coefficients were cleared, so the impulse response is all zeros
      for (int i = 0; i < 4; i++) begin
         send(imp_x[i]);
         wait_drain();
         check("cleared_coef_hold", int'(Yout), 0);
      end

      repeat (3) cyc();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_fir_tap_scheduler
`default_nettype wire
